note_glyph_renderer: RTL and testbench

Parametrised note-label renderer for the VGA path. On a start pulse it latches a note code, octave code and screen origin, then streams one pixel per clock to the VGA adapter. It covers a row of NUM_GLYPHS glyph slots (sharp, letter, octave digit, then blank padding), scaled by SCALE. Every pixel is written foreground or background, so a redraw erases the previous label. A separate clear command fills the whole screen with background. It sits between the note/octave decode logic and the VGA adapter's x/y/colour/writeEn inputs.

---
 rtl/note_glyph_renderer_if.sv | 30 +++
 rtl/note_glyph_renderer.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_note_glyph_renderer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/note_glyph_renderer_if.sv
// note_glyph_renderer_if
// Bundles the command side (start/clear, note/octave, label origin) and the
// pixel side (x_out/y_out/colour/writeEn plus busy/done status) of the note
// label renderer.
//   master : the note/octave decode logic; drives commands, observes pixels.
//   slave  : the renderer; receives commands, drives the VGA pixel stream.
interface note_glyph_renderer_if;
  logic       start;
  logic       clear;
  logic [3:0] note;
  logic [1:0] octave;
  logic [7:0] x;
  logic [6:0] y;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       writeEn;
  logic       busy;
  logic       done;

  modport master (
    output start, clear, note, octave, x, y,
    input  x_out, y_out, colour, writeEn, busy, done
  );

  modport slave (
    input  start, clear, note, octave, x, y,
    output x_out, y_out, colour, writeEn, busy, done
  );
endinterface

// File: rtl/note_glyph_renderer.sv
// note_glyph_renderer
// Streams one pixel per clock to the VGA adapter. A start command draws a row
// of NUM_GLYPHS glyph slots (sharp, letter, octave digit, blank padding), each
// 12x12 scaled by SCALE, writing every pixel as foreground or background so a
// redraw erases the old label. A clear command sweeps the whole screen with
// the background colour. Pixels falling off-screen are skipped (writeEn low)
// but still take their cycle.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : slave side of note_glyph_renderer_if (commands in, pixels out)
module note_glyph_renderer #(
  parameter int         SCALE      = 1,
  parameter int         NUM_GLYPHS = 3,
  parameter int         SCREEN_W   = 160,
  parameter int         SCREEN_H   = 120,
  parameter logic [2:0] FG_COLOUR  = 3'b010,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  note_glyph_renderer_if.slave  bus
);

  localparam logic [1:0] SUB_MAX   = 2'(SCALE - 1);
  localparam logic [2:0] SLOT_MAX  = 3'(NUM_GLYPHS - 1);
  localparam logic [9:0] SLOT_STEP = 10'(12 * SCALE);
  localparam logic [9:0] W_LIM     = 10'(SCREEN_W);
  localparam logic [7:0] H_LIM     = 8'(SCREEN_H);
  localparam logic [7:0] CX_MAX    = 8'(SCREEN_W - 1);
  localparam logic [6:0] CY_MAX    = 7'(SCREEN_H - 1);

  localparam logic [3:0] G_A = 4'd0,  G_B = 4'd1,  G_C = 4'd2,  G_D = 4'd3;
  localparam logic [3:0] G_E = 4'd4,  G_F = 4'd5,  G_G = 4'd6,  G_HASH = 4'd7;
  localparam logic [3:0] G_1 = 4'd8,  G_2 = 4'd9,  G_3 = 4'd10, G_4 = 4'd11;
  localparam logic [3:0] G_BLANK = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DRAW, S_DONE} state_t;

  // 12 rows of 12 bits, row 0 in the top bits, column 0 the MSB of each row.
  function automatic logic [143:0] glyph_bitmap(input logic [3:0] g);
    case (g)
      G_A:    return {12'h000, 12'h060, 12'h090, 12'h108, 12'h204, 12'h204,
                      12'h3FC, 12'h204, 12'h204, 12'h204, 12'h000, 12'h000};
      G_B:    return {12'h000, 12'h7F0, 12'h408, 12'h408, 12'h408, 12'h7F0,
                      12'h408, 12'h408, 12'h408, 12'h7F0, 12'h000, 12'h000};
      G_C:    return {12'h000, 12'h3F8, 12'h400, 12'h400, 12'h400, 12'h400,
                      12'h400, 12'h400, 12'h400, 12'h3F8, 12'h000, 12'h000};
      G_D:    return {12'h000, 12'h7E0, 12'h410, 12'h408, 12'h408, 12'h408,
                      12'h408, 12'h408, 12'h410, 12'h7E0, 12'h000, 12'h000};
      G_E:    return {12'h000, 12'h7FC, 12'h400, 12'h400, 12'h400, 12'h7F0,
                      12'h400, 12'h400, 12'h400, 12'h7FC, 12'h000, 12'h000};
      G_F:    return {12'h000, 12'h7FC, 12'h400, 12'h400, 12'h400, 12'h7F0,
                      12'h400, 12'h400, 12'h400, 12'h400, 12'h000, 12'h000};
      G_G:    return {12'h000, 12'h3F8, 12'h400, 12'h400, 12'h400, 12'h47C,
                      12'h408, 12'h408, 12'h408, 12'h3F8, 12'h000, 12'h000};
      G_HASH: return {12'h000, 12'h330, 12'h330, 12'h7FE, 12'h330, 12'h330,
                      12'h7FE, 12'h330, 12'h330, 12'h330, 12'h000, 12'h000};
      G_1:    return {12'h000, 12'h018, 12'h038, 12'h058, 12'h018, 12'h018,
                      12'h018, 12'h018, 12'h018, 12'h07E, 12'h000, 12'h000};
      G_2:    return {12'h000, 12'h0F0, 12'h108, 12'h008, 12'h010, 12'h020,
                      12'h040, 12'h080, 12'h100, 12'h1F8, 12'h000, 12'h000};
      G_3:    return {12'h000, 12'h1F0, 12'h008, 12'h008, 12'h008, 12'h0F0,
                      12'h008, 12'h008, 12'h008, 12'h1F0, 12'h000, 12'h000};
      G_4:    return {12'h000, 12'h108, 12'h108, 12'h108, 12'h108, 12'h1FC,
                      12'h008, 12'h008, 12'h008, 12'h008, 12'h000, 12'h000};
      default: return '0;
    endcase
  endfunction

  // Which glyph occupies a slot for the latched note/octave.
  function automatic logic [3:0] slot_glyph(input logic [2:0] slot,
                                            input logic [3:0] nt,
                                            input logic [1:0] oct);
    logic [3:0] g;
    g = G_BLANK;
    case (slot)
      3'd0: begin
        case (nt)
          4'd2, 4'd5, 4'd7, 4'd10, 4'd12: g = G_HASH;
          default:                        g = G_BLANK;
        endcase
      end
      3'd1: begin
        case (nt)
          4'd1, 4'd2:   g = G_A;
          4'd3:         g = G_B;
          4'd4, 4'd5:   g = G_C;
          4'd6, 4'd7:   g = G_D;
          4'd8:         g = G_E;
          4'd9, 4'd10:  g = G_F;
          4'd11, 4'd12: g = G_G;
          default:      g = G_BLANK;
        endcase
      end
      3'd2:    g = G_1 + {2'b00, oct};
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic on_screen(input logic [9:0] col, input logic [7:0] row);
    return (col < W_LIM) && (row < H_LIM);
  endfunction

  state_t     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [3:0] gr_q, gr_d;          // glyph source row
  logic [1:0] rs_q, rs_d;          // replication count within a source row
  logic [3:0] gc_q, gc_d;          // glyph source column
  logic [1:0] cs_q, cs_d;          // replication count within a source column
  logic [5:0] sr_q, sr_d;          // scaled row within the glyph
  logic [5:0] sc_q, sc_d;          // scaled column within the glyph
  logic [9:0] slot_x_q, slot_x_d;  // column offset of the current slot
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;
  logic       last_q, last_d;      // final pixel already emitted
  logic [7:0] x_out_q, x_out_d;
  logic [6:0] y_out_q, y_out_d;
  logic [2:0] colour_q, colour_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] note_q, note_d;
  logic [1:0] oct_q, oct_d;
  logic [7:0] ox_q, ox_d;
  logic [6:0] oy_q, oy_d;

  logic [143:0] cur_bitmap;
  logic [7:0]   bit_idx;
  logic         src_bit;
  logic [9:0]   col_sum;   // wide enough that no slot offset wraps back on-screen
  logic [7:0]   row_sum;

  assign cur_bitmap = glyph_bitmap(slot_glyph(slot_q, note_q, oct_q));
  assign bit_idx    = 8'd143 - (8'd12 * {4'b0000, gr_q} + {4'b0000, gc_q});
  assign src_bit    = cur_bitmap[bit_idx];
  assign col_sum    = {2'b00, ox_q} + slot_x_q + {4'b0000, sc_q};
  assign row_sum    = {1'b0, oy_q} + {2'b00, sr_q};

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    gr_d     = gr_q;
    rs_d     = rs_q;
    gc_d     = gc_q;
    cs_d     = cs_q;
    sr_d     = sr_q;
    sc_d     = sc_q;
    slot_x_d = slot_x_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    last_d   = last_q;
    x_out_d  = x_out_q;
    y_out_d  = y_out_q;
    colour_d = colour_q;
    we_d     = 1'b0;
    done_d   = 1'b0;
    note_d   = note_q;
    oct_d    = oct_q;
    ox_d     = ox_q;
    oy_d     = oy_q;

    case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          state_d = S_CLEAR;
          cx_d    = '0;
          cy_d    = '0;
          last_d  = 1'b0;
        end else if (bus.start) begin
          state_d  = S_DRAW;
          note_d   = bus.note;
          oct_d    = bus.octave;
          ox_d     = bus.x;
          oy_d     = bus.y;
          slot_d   = '0;
          gr_d     = '0;
          rs_d     = '0;
          gc_d     = '0;
          cs_d     = '0;
          sr_d     = '0;
          sc_d     = '0;
          slot_x_d = '0;
          last_d   = 1'b0;
        end
      end

      S_CLEAR: begin
        if (last_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          x_out_d  = cx_q;
          y_out_d  = cy_q;
          colour_d = BG_COLOUR;
          we_d     = 1'b1;
          if (cx_q == CX_MAX) begin
            cx_d = '0;
            if (cy_q == CY_MAX) last_d = 1'b1;
            else                cy_d   = cy_q + 7'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end
      end

      S_DRAW: begin
        if (last_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          x_out_d  = col_sum[7:0];
          y_out_d  = row_sum[6:0];
          colour_d = src_bit ? FG_COLOUR : BG_COLOUR;
          we_d     = on_screen(col_sum, row_sum);
          // Column sub-counter steps the source column every SCALE pixels,
          // so the source bit is (sr/SCALE, sc/SCALE) without dividing.
          sc_d = sc_q + 6'd1;
          if (cs_q == SUB_MAX) begin
            cs_d = '0;
            gc_d = gc_q + 4'd1;
          end else begin
            cs_d = cs_q + 2'd1;
          end
          if ((gc_q == 4'd11) && (cs_q == SUB_MAX)) begin
            gc_d = '0;
            sc_d = '0;
            sr_d = sr_q + 6'd1;
            if (rs_q == SUB_MAX) begin
              rs_d = '0;
              gr_d = gr_q + 4'd1;
            end else begin
              rs_d = rs_q + 2'd1;
            end
            if ((gr_q == 4'd11) && (rs_q == SUB_MAX)) begin
              gr_d     = '0;
              sr_d     = '0;
              slot_d   = slot_q + 3'd1;
              slot_x_d = slot_x_q + SLOT_STEP;
              if (slot_q == SLOT_MAX) last_d = 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CLEAR) || (state_d == S_DRAW);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      gr_q     <= '0;
      rs_q     <= '0;
      gc_q     <= '0;
      cs_q     <= '0;
      sr_q     <= '0;
      sc_q     <= '0;
      slot_x_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      last_q   <= 1'b0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      colour_q <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      gr_q     <= gr_d;
      rs_q     <= rs_d;
      gc_q     <= gc_d;
      cs_q     <= cs_d;
      sr_q     <= sr_d;
      sc_q     <= sc_d;
      slot_x_q <= slot_x_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      last_q   <= last_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      colour_q <= colour_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Latched label parameters are plain data; they are always rewritten
  // before use, so they carry no reset.
  always_ff @(posedge clk) begin
    note_q <= note_d;
    oct_q  <= oct_d;
    ox_q   <= ox_d;
    oy_q   <= oy_d;
  end

  assign bus.x_out   = x_out_q;
  assign bus.y_out   = y_out_q;
  assign bus.colour  = colour_q;
  assign bus.writeEn = we_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_note_glyph_renderer.sv
// tb_note_glyph_renderer
// Drives a SCALE=1 and a SCALE=2 renderer from one set of command signals
// (sel picks the target) and checks the pixel stream against a reference
// model that derives every pixel from its index with plain arithmetic.
module tb_note_glyph_renderer;

  localparam int FG = 2;
  localparam int BG = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_start, cmd_clear;
  logic [3:0] note;
  logic [1:0] octave;
  logic [7:0] ox;
  logic [6:0] oy;
  int         sel;

  int n_cmp = 0;
  int n_bad = 0;

  note_glyph_renderer_if if0();
  note_glyph_renderer_if if1();

  assign if0.start  = cmd_start && (sel == 0);
  assign if0.clear  = cmd_clear && (sel == 0);
  assign if0.note   = note;
  assign if0.octave = octave;
  assign if0.x      = ox;
  assign if0.y      = oy;
  assign if1.start  = cmd_start && (sel == 1);
  assign if1.clear  = cmd_clear && (sel == 1);
  assign if1.note   = note;
  assign if1.octave = octave;
  assign if1.x      = ox;
  assign if1.y      = oy;

  logic [7:0] o_x;
  logic [6:0] o_y;
  logic [2:0] o_col;
  logic       o_we, o_busy, o_done;
  assign o_x    = (sel == 1) ? if1.x_out   : if0.x_out;
  assign o_y    = (sel == 1) ? if1.y_out   : if0.y_out;
  assign o_col  = (sel == 1) ? if1.colour  : if0.colour;
  assign o_we   = (sel == 1) ? if1.writeEn : if0.writeEn;
  assign o_busy = (sel == 1) ? if1.busy    : if0.busy;
  assign o_done = (sel == 1) ? if1.done    : if0.done;

  note_glyph_renderer #(.SCALE(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  note_glyph_renderer #(.SCALE(2)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Glyph artwork as 12 rows, column 0 at bit 11.
  function automatic int font_row(input byte ch, input int r);
    logic [11:0] rows [12];
    case (ch)
      "A": rows = '{12'h000, 12'h060, 12'h090, 12'h108, 12'h204, 12'h204, 12'h3FC, 12'h204, 12'h204, 12'h204, 12'h000, 12'h000};
      "B": rows = '{12'h000, 12'h7F0, 12'h408, 12'h408, 12'h408, 12'h7F0, 12'h408, 12'h408, 12'h408, 12'h7F0, 12'h000, 12'h000};
      "C": rows = '{12'h000, 12'h3F8, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'h3F8, 12'h000, 12'h000};
      "D": rows = '{12'h000, 12'h7E0, 12'h410, 12'h408, 12'h408, 12'h408, 12'h408, 12'h408, 12'h410, 12'h7E0, 12'h000, 12'h000};
      "E": rows = '{12'h000, 12'h7FC, 12'h400, 12'h400, 12'h400, 12'h7F0, 12'h400, 12'h400, 12'h400, 12'h7FC, 12'h000, 12'h000};
      "F": rows = '{12'h000, 12'h7FC, 12'h400, 12'h400, 12'h400, 12'h7F0, 12'h400, 12'h400, 12'h400, 12'h400, 12'h000, 12'h000};
      "G": rows = '{12'h000, 12'h3F8, 12'h400, 12'h400, 12'h400, 12'h47C, 12'h408, 12'h408, 12'h408, 12'h3F8, 12'h000, 12'h000};
      "#": rows = '{12'h000, 12'h330, 12'h330, 12'h7FE, 12'h330, 12'h330, 12'h7FE, 12'h330, 12'h330, 12'h330, 12'h000, 12'h000};
      "1": rows = '{12'h000, 12'h018, 12'h038, 12'h058, 12'h018, 12'h018, 12'h018, 12'h018, 12'h018, 12'h07E, 12'h000, 12'h000};
      "2": rows = '{12'h000, 12'h0F0, 12'h108, 12'h008, 12'h010, 12'h020, 12'h040, 12'h080, 12'h100, 12'h1F8, 12'h000, 12'h000};
      "3": rows = '{12'h000, 12'h1F0, 12'h008, 12'h008, 12'h008, 12'h0F0, 12'h008, 12'h008, 12'h008, 12'h1F0, 12'h000, 12'h000};
      "4": rows = '{12'h000, 12'h108, 12'h108, 12'h108, 12'h108, 12'h1FC, 12'h008, 12'h008, 12'h008, 12'h008, 12'h000, 12'h000};
      default: rows = '{default: 12'h000};
    endcase
    return int'(rows[r]);
  endfunction

  function automatic byte slot_char(input int slot, input int nt, input int oc);
    string sharps, letters, digits;
    sharps  = " #  # #  # #";
    letters = "AABCCDDEFFGG";
    digits  = "1234";
    if (slot == 0) return (nt >= 1 && nt <= 12) ? sharps[nt-1] : 8'h20;
    if (slot == 1) return (nt >= 1 && nt <= 12) ? letters[nt-1] : 8'h20;
    if (slot == 2) return digits[oc];
    return 8'h20;
  endfunction

  // Pixel k of a label draw, straight from the geometry rules.
  task automatic model_pixel(input int scale, input int nt, input int oc,
                             input int x0, input int y0, input int k,
                             output int px, output int py, output int pc, output int pw);
    int side, per, slot, rem, sr, sc, colsum, rowsum, bitv;
    side   = 12 * scale;
    per    = side * side;
    slot   = k / per;
    rem    = k % per;
    sr     = rem / side;
    sc     = rem % side;
    bitv   = (font_row(slot_char(slot, nt, oc), sr / scale) >> (11 - sc / scale)) & 1;
    colsum = x0 + slot * side + sc;
    rowsum = y0 + sr;
    px     = colsum % 256;
    py     = rowsum % 128;
    pc     = bitv ? FG : BG;
    pw     = (colsum < 160 && rowsum < 120) ? 1 : 0;
  endtask

  int cap_x [1728];
  int cap_y [1728];
  int cap_c [1728];
  int cap_w [1728];

  function automatic int probe_colour(input int total, input int px, input int py);
    for (int k = 0; k < total; k++)
      if (cap_w[k] == 1 && cap_x[k] == px && cap_y[k] == py) return cap_c[k];
    return -1;
  endfunction

  // Issues a start from the IDLE negedge, captures every pixel cycle, then
  // checks the done cycle and the return to idle.
  task automatic run_draw(input int s, input int nt, input int oc, input int x0, input int y0,
                          input int exp_writes, input int prx, input int pry, input int prc,
                          input string tag);
    int scale, total, bad, writes, mwrites, px, py, pc, pw;
    scale = (s == 1) ? 2 : 1;
    total = 3 * 144 * scale * scale;
    sel    = s;
    note   = 4'(nt);
    octave = 2'(oc);
    ox     = 8'(x0);
    oy     = 7'(y0);
    cmd_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_start = 1'b0;
    check({tag, "/busy_on"}, o_busy, 1);
    bad = 0; writes = 0; mwrites = 0;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      cap_x[k] = o_x; cap_y[k] = o_y; cap_c[k] = o_col; cap_w[k] = o_we;
      model_pixel(scale, nt, oc, x0, y0, k, px, py, pc, pw);
      mwrites += pw;
      writes  += o_we;
      if (o_we !== pw[0] || o_busy !== 1'b1 || o_done !== 1'b0 ||
          (pw == 1 && (o_x != px || o_y != py || o_col != pc)))
        bad++;
    end
    check({tag, "/pixel_stream_bad_count"}, bad, 0);
    check({tag, "/writes"}, writes, (exp_writes < 0) ? mwrites : exp_writes);
    @(negedge clk);
    check({tag, "/done"}, o_done, 1);
    check({tag, "/busy_we_at_done"}, {o_busy, o_we}, 0);
    @(negedge clk);
    check({tag, "/done_once"}, {o_done, o_busy, o_we}, 0);
    if (prx >= 0) check({tag, "/probe_colour"}, probe_colour(total, prx, pry), prc);
  endtask

  typedef struct {
    int s; int nt; int oc; int x; int y;
    int writes; int px; int py; int col;
  } vec_t;
  vec_t vecs [12];

  initial begin
    int bad, cnt;
    vecs[0]  = '{0, 2, 0, 10, 20, 432, 10, 20, BG};
    vecs[1]  = '{0, 2, 0, 10, 20, 432, 12, 21, FG};
    vecs[2]  = '{0, 2, 0, 10, 20, 432, 27, 21, FG};
    vecs[3]  = '{0, 2, 0, 10, 20, 432, 42, 21, FG};
    vecs[4]  = '{1, 2, 0, 0, 0, 1728, 4, 2, FG};
    vecs[5]  = '{1, 2, 0, 0, 0, 1728, 5, 3, FG};
    vecs[6]  = '{1, 2, 0, 0, 0, 1728, 4, 3, FG};
    vecs[7]  = '{1, 2, 0, 0, 0, 1728, 2, 0, BG};
    vecs[8]  = '{0, 4, 0, 150, 115, 50, 150, 115, BG};
    vecs[9]  = '{0, 0, 3, 0, 0, 432, 27, 1, FG};
    vecs[10] = '{0, 0, 3, 0, 0, 432, 2, 1, BG};
    vecs[11] = '{0, 0, 3, 0, 0, 432, 15, 6, BG};

    reset = 1'b1; cmd_start = 1'b0; cmd_clear = 1'b0; sel = 0;
    note = '0; octave = '0; ox = '0; oy = '0;
    repeat (3) @(negedge clk);
    check("reset_state_s1", {o_x, o_y, o_col, o_we, o_busy, o_done}, 0);
    sel = 1; #1;
    check("reset_state_s2", {o_x, o_y, o_col, o_we, o_busy, o_done}, 0);
    sel = 0;
    reset = 1'b0;
    @(negedge clk);

    // Table entries run back to back: each start lands on the first idle cycle.
    for (int i = 0; i < 12; i++)
      run_draw(vecs[i].s, vecs[i].nt, vecs[i].oc, vecs[i].x, vecs[i].y,
               vecs[i].writes, vecs[i].px, vecs[i].py, vecs[i].col, $sformatf("vec%0d", i));

    // Clear and start together: clear wins.
    sel = 0; cmd_clear = 1'b1; cmd_start = 1'b1; note = 4'd2; ox = 8'd10; oy = 7'd20;
    @(posedge clk);
    @(negedge clk);
    cmd_clear = 1'b0; cmd_start = 1'b0;
    check("clear/busy_on", o_busy, 1);
    bad = 0;
    for (int k = 0; k < 19200; k++) begin
      @(negedge clk);
      if (o_we !== 1'b1 || o_x != 8'(k % 160) || o_y != 7'(k / 160) ||
          o_col != 3'(BG) || o_busy !== 1'b1 || o_done !== 1'b0)
        bad++;
    end
    check("clear/sweep_bad_count", bad, 0);
    @(negedge clk);
    check("clear/done", {o_done, o_busy, o_we}, 3'b100);
    @(negedge clk);
    check("clear/start_dropped", {o_done, o_busy, o_we}, 0);

    // Asynchronous reset in the middle of a draw.
    sel = 0; note = 4'd2; octave = 2'd0; ox = 8'd10; oy = 7'd20;
    cmd_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (101) @(negedge clk);
    check("rst/pixel100_pos", {o_x, o_y}, {8'd14, 7'd28});
    reset = 1'b1;
    #1;
    check("rst/outs_zero", {o_x, o_y, o_col, o_we, o_busy, o_done}, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cnt += int'(o_we) + int'(o_done) + int'(o_busy);
    end
    check("rst/quiet_after", cnt, 0);
    run_draw(0, 2, 0, 10, 20, 432, 10, 20, BG, "rst_redraw");

    // Randomised labels, mostly at SCALE=1, with origins that often clip.
    for (int i = 0; i < 10; i++)
      run_draw(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 15), $urandom_range(0, 3),
               $urandom_range(0, 255), $urandom_range(0, 127), -1, -1, 0, 0,
               $sformatf("rand%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
